// File: rtl/alu_control_md_pkg.sv
// Shared encodings for the execute-stage ALU control: select codes, R-type
// function fields, main-control ALU classes and the multiply/divide FSM states.
package alu_control_md_pkg;

  localparam logic [3:0] SEL_AND     = 4'b0000;
  localparam logic [3:0] SEL_OR      = 4'b0001;
  localparam logic [3:0] SEL_ADD     = 4'b0010;
  localparam logic [3:0] SEL_SUB     = 4'b0110;
  localparam logic [3:0] SEL_SLT     = 4'b0111;
  localparam logic [3:0] SEL_NOR     = 4'b1100;
  localparam logic [3:0] SEL_XOR     = 4'b1101;
  localparam logic [3:0] SEL_PASS_HI = 4'b1000;
  localparam logic [3:0] SEL_PASS_LO = 4'b1001;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_OR    = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } mdState_t;

endpackage

// File: rtl/alu_control_md_md_unit.sv
// Iterative unsigned multiply/divide, one bit per cycle, owning HI/LO.
// HI/LO change only on the last iteration so readers never see partial results.
module md_unit
  import alu_control_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH);

  mdState_t         state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic             lastIter;
  logic             load;
  logic [WIDTH-1:0] operand, accHi, accLo, accHiNext, accLoNext;
  logic [WIDTH:0]   mulSum, divShift;

  assign busy     = (state != MD_IDLE);
  assign lastIter = (cnt == CNT_W'(WIDTH - 1));
  assign load     = start && (state == MD_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= MD_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      MD_IDLE: if (start) stateNext = isDiv ? MD_DIV : MD_MUL;
      MD_MUL,
      MD_DIV:  if (lastIter) stateNext = MD_IDLE;
      default: stateNext = MD_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (busy) cnt <= lastIter ? '0 : cnt + 1'b1;
  end

  // Mul: accHi = partial product, accLo = multiplier. Div: accHi = remainder, accLo = quotient.
  always_comb begin
    mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    divShift  = {accHi, accLo[WIDTH-1]};
    accHiNext = accHi;
    accLoNext = accLo;
    if (state == MD_MUL) begin
      {accHiNext, accLoNext} = {mulSum, accLo[WIDTH-1:1]};
    end else if (state == MD_DIV) begin
      if (divShift >= {1'b0, operand}) begin
        accHiNext = WIDTH'(divShift - {1'b0, operand});
        accLoNext = {accLo[WIDTH-2:0], 1'b1};
      end else begin
        accHiNext = divShift[WIDTH-1:0];
        accLoNext = {accLo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // A zero divisor always "fits", giving all-ones quotient and the dividend as remainder.
  always_ff @(posedge Clk) begin
    if (load) begin
      operand <= isDiv ? opB : opA;
      accHi   <= '0;
      accLo   <= isDiv ? opA : opB;
    end else begin
      accHi   <= accHiNext;
      accLo   <= accLoNext;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (busy && lastIter) begin
      hi <= accHiNext;
      lo <= accLoNext;
    end
  end

endmodule

// File: rtl/alu_control_md.sv
// Execute-stage ALU control: decodes AluOp/Func into the ID/EX select register,
// starts the multiply/divide unit and stalls HI/LO-dependent instructions while it runs.
module alu_control_md
  import alu_control_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIG_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  input  logic [1:0]       AluOp,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic [SIG_W-1:0] AluSig,
  output logic             ExValid,
  output logic             Illegal,
  output logic             Stall,
  output logic             Busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  logic [4:0]       dec;
  logic             isRType, mdFunc, isMdOp, accepted, mdStart;
  logic [SIG_W-1:0] aluSig_p1;
  logic             vld_p1, illegal_p1;

  // Returns {illegal, select}.
  function automatic logic [4:0] decodeSel(input logic [1:0] aluOp, input logic [5:0] func);
    logic [4:0] r;
    r = {1'b0, SEL_ADD};
    case (aluOp)
      AOP_ADD: r = {1'b0, SEL_ADD};
      AOP_SUB: r = {1'b0, SEL_SUB};
      AOP_OR:  r = {1'b0, SEL_OR};
      default: begin
        case (func)
          FN_ADD, FN_ADDU, FN_MULTU, FN_DIVU: r = {1'b0, SEL_ADD};
          FN_SUB, FN_SUBU: r = {1'b0, SEL_SUB};
          FN_AND:          r = {1'b0, SEL_AND};
          FN_OR:           r = {1'b0, SEL_OR};
          FN_XOR:          r = {1'b0, SEL_XOR};
          FN_NOR:          r = {1'b0, SEL_NOR};
          FN_SLT:          r = {1'b0, SEL_SLT};
          FN_MFHI:         r = {1'b0, SEL_PASS_HI};
          FN_MFLO:         r = {1'b0, SEL_PASS_LO};
          default:         r = {1'b1, SEL_ADD};
        endcase
      end
    endcase
    return r;
  endfunction

  assign dec      = decodeSel(AluOp, Func);
  assign isRType  = (AluOp == AOP_RTYPE);
  assign isMdOp   = (Func == FN_MULTU) || (Func == FN_DIVU);
  assign mdFunc   = isMdOp || (Func == FN_MFHI) || (Func == FN_MFLO);
  assign Stall    = InValid && Busy && isRType && mdFunc;
  assign accepted = InValid && !Stall;
  assign mdStart  = accepted && isRType && isMdOp;

  md_unit #(.WIDTH(WIDTH)) uMd (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .start (mdStart),
    .isDiv (Func == FN_DIVU),
    .opA   (OpA),
    .opB   (OpB),
    .busy  (Busy),
    .hi    (Hi),
    .lo    (Lo)
  );

  // ID/EX boundary: anything not accepted becomes a bubble.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      aluSig_p1  <= SIG_W'(SEL_ADD);
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (accepted) begin
      aluSig_p1  <= SIG_W'(dec[3:0]);
      vld_p1     <= 1'b1;
      illegal_p1 <= dec[4];
    end else begin
      aluSig_p1  <= SIG_W'(SEL_ADD);
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
    end
  end

  assign AluSig  = aluSig_p1;
  assign ExValid = vld_p1;
  assign Illegal = illegal_p1;

endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: decode table, multiply/divide against arithmetic
// reference results, MFLO hazard stalling and reset in the middle of an operation.
module tb_alu_control_md;
  localparam int WIDTH = 32;
  localparam int SIG_W = 4;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             InValid = 1'b0;
  logic [1:0]       AluOp = 2'b00;
  logic [5:0]       Func = 6'h00;
  logic [WIDTH-1:0] OpA = '0;
  logic [WIDTH-1:0] OpB = '0;
  logic [SIG_W-1:0] AluSig;
  logic             ExValid, Illegal, Stall, Busy;
  logic [WIDTH-1:0] Hi, Lo;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  alu_control_md #(.WIDTH(WIDTH), .SIG_W(SIG_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .AluOp(AluOp), .Func(Func),
    .OpA(OpA), .OpB(OpB), .AluSig(AluSig), .ExValid(ExValid), .Illegal(Illegal),
    .Stall(Stall), .Busy(Busy), .Hi(Hi), .Lo(Lo)
  );

  typedef struct {
    logic [1:0] aluOp;
    logic [5:0] func;
    logic [3:0] sig;
    logic       ill;
  } decVec_t;

  decVec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // {Hi, Lo} from plain arithmetic.
  function automatic logic [63:0] mdRef(input bit isDiv, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (!isDiv)      r = 64'(a) * 64'(b);
    else if (b == 0) r = {a, 32'hFFFF_FFFF};
    else             r = {a % b, a / b};
    return r;
  endfunction

  task automatic runMd(input bit isDiv, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    logic [31:0] oldHi, oldLo;
    int n;
    bit held;
    exp   = mdRef(isDiv, a, b);
    oldHi = Hi;
    oldLo = Lo;
    InValid = 1'b1; AluOp = 2'b10; Func = isDiv ? 6'h1B : 6'h19; OpA = a; OpB = b;
    tick();
    InValid = 1'b0; OpA = $urandom; OpB = $urandom;
    check({tag, " start ExValid"}, ExValid, 1);
    check({tag, " start AluSig"}, AluSig, 4'b0010);
    n = 0;
    held = 1'b1;
    while (Busy === 1'b1 && n <= WIDTH + 4) begin
      if (Hi !== oldHi || Lo !== oldLo) held = 1'b0;
      n++;
      tick();
    end
    check({tag, " busy cycles"}, n, WIDTH);
    check({tag, " HiLo held while busy"}, held, 1);
    check({tag, " Hi"}, Hi, exp[63:32]);
    check({tag, " Lo"}, Lo, exp[31:0]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp;
    logic [31:0] ra, rb;

    // Reset
    repeat (3) tick();
    check("rst AluSig", AluSig, 4'b0010);
    check("rst ExValid", ExValid, 0);
    check("rst Illegal", Illegal, 0);
    check("rst Busy", Busy, 0);
    check("rst Hi", Hi, 0);
    check("rst Lo", Lo, 0);
    Rst_n = 1'b1;
    tick();
    check("post-rst ExValid", ExValid, 0);
    check("post-rst Busy", Busy, 0);

    // Decode sweep
    vecs.push_back('{2'b10, 6'h20, 4'b0010, 1'b0});
    vecs.push_back('{2'b10, 6'h21, 4'b0010, 1'b0});
    vecs.push_back('{2'b10, 6'h22, 4'b0110, 1'b0});
    vecs.push_back('{2'b10, 6'h23, 4'b0110, 1'b0});
    vecs.push_back('{2'b10, 6'h24, 4'b0000, 1'b0});
    vecs.push_back('{2'b10, 6'h25, 4'b0001, 1'b0});
    vecs.push_back('{2'b10, 6'h26, 4'b1101, 1'b0});
    vecs.push_back('{2'b10, 6'h27, 4'b1100, 1'b0});
    vecs.push_back('{2'b10, 6'h2A, 4'b0111, 1'b0});
    vecs.push_back('{2'b10, 6'h10, 4'b1000, 1'b0});
    vecs.push_back('{2'b10, 6'h12, 4'b1001, 1'b0});
    vecs.push_back('{2'b10, 6'h3F, 4'b0010, 1'b1});
    vecs.push_back('{2'b10, 6'h00, 4'b0010, 1'b1});
    vecs.push_back('{2'b00, 6'h26, 4'b0010, 1'b0});
    vecs.push_back('{2'b01, 6'h3F, 4'b0110, 1'b0});
    vecs.push_back('{2'b11, 6'h22, 4'b0001, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      InValid = 1'b1; AluOp = vecs[i].aluOp; Func = vecs[i].func;
      OpA = $urandom; OpB = $urandom;
      tick();
      check($sformatf("dec[%0d] AluSig", i), AluSig, vecs[i].sig);
      check($sformatf("dec[%0d] ExValid", i), ExValid, 1);
      check($sformatf("dec[%0d] Illegal", i), Illegal, vecs[i].ill);
      check($sformatf("dec[%0d] Busy", i), Busy, 0);
    end
    InValid = 1'b0; AluOp = 2'b10; Func = 6'h3F;
    tick();
    check("idle ExValid", ExValid, 0);
    check("idle Illegal", Illegal, 0);
    check("idle AluSig", AluSig, 4'b0010);

    // Directed multiply/divide
    runMd(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul max");
    runMd(1'b1, 32'd100, 32'd7, "div 100/7");
    runMd(1'b1, 32'd5, 32'd0, "div by zero");

    // Randomized multiply/divide
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      runMd(i[0], ra, rb, $sformatf("rand[%0d]", i));
    end

    // Hazard: MFLO right behind MULTU
    ra = 32'h1234_5678; rb = 32'h0000_9ABC;
    exp = mdRef(1'b0, ra, rb);
    InValid = 1'b1; AluOp = 2'b10; Func = 6'h19; OpA = ra; OpB = rb;
    tick();
    Func = 6'h12; OpA = $urandom; OpB = $urandom;
    for (int n = 0; n < WIDTH; n++) begin
      check($sformatf("haz[%0d] Stall", n), Stall, 1);
      check($sformatf("haz[%0d] Busy", n), Busy, 1);
      if (n > 0) check($sformatf("haz[%0d] bubble", n), {ExValid, AluSig}, {1'b0, 4'b0010});
      tick();
    end
    check("haz release Stall", Stall, 0);
    check("haz release Busy", Busy, 0);
    check("haz Lo", Lo, exp[31:0]);
    check("haz Hi", Hi, exp[63:32]);
    tick();
    InValid = 1'b0;
    check("haz MFLO ExValid", ExValid, 1);
    check("haz MFLO AluSig", AluSig, 4'b1001);
    check("haz MFLO no restart", Busy, 0);

    // Reset in the middle of a divide
    InValid = 1'b1; AluOp = 2'b10; Func = 6'h1B; OpA = 32'd1000; OpB = 32'd3;
    tick();
    InValid = 1'b0;
    repeat (10) tick();
    check("midrst busy before", Busy, 1);
    Rst_n = 1'b0;
    #1;
    check("midrst Busy", Busy, 0);
    check("midrst Hi", Hi, 0);
    check("midrst Lo", Lo, 0);
    check("midrst ExValid", ExValid, 0);
    tick();
    Rst_n = 1'b1;
    tick();
    runMd(1'b0, 32'd3, 32'd4, "mul after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
